// File: rtl/cordic_hyper_pkg.sv
// rtl/cordic_hyper_pkg.sv - hyperbolic CORDIC constants, iteration schedule and rescaling helpers
package cordic_hyper_pkg;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  localparam logic [63:0] KH_INV_Q32 = 64'd5186162702;
  localparam logic [63:0] ZMAX_Q32   = 64'd4802632430;

  // atanh(2^-i) with 32 fractional bits, i = 1..24
  localparam logic [63:0] ATANH_Q32 [1:24] = '{
    64'd2359251925, 64'd1096989674, 64'd539693625, 64'd268785803,
    64'd134261444,  64'd67114326,   64'd33555115,  64'd16777301,
    64'd8388619,    64'd4194305,    64'd2097152,   64'd1048576,
    64'd524288,     64'd262144,     64'd131072,    64'd65536,
    64'd32768,      64'd16384,      64'd8192,      64'd4096,
    64'd2048,       64'd1024,       64'd512,       64'd256
  };

  function automatic logic is_repeat(input int i);
    return (i == 4) || (i == 13) || (i == 40);
  endfunction

  function automatic int nstep(input int iter);
    int n;
    n = iter;
    for (int i = 1; i <= iter; i++)
      if (is_repeat(i)) n++;
    return n;
  endfunction

  // Stage number (0-based) to iteration index, with repeated indices occupying two stages.
  function automatic int stage_index(input int s);
    int k;
    int idx;
    k   = 0;
    idx = 0;
    for (int i = 1; i <= 40; i++)
      for (int r = 0; r < 2; r++)
        if (r == 0 || is_repeat(i)) begin
          if (k == s) idx = i;
          k++;
        end
    return idx;
  endfunction

  function automatic logic [63:0] q32_to_frac(input logic [63:0] v, input int frac);
    return (v + (64'd1 << (31 - frac))) >> (32 - frac);
  endfunction

endpackage

// File: rtl/cordic_hyper_stage.sv
// rtl/cordic_hyper_stage.sv - one registered hyperbolic CORDIC micro-iteration
// CORDIC_RANGE_CHK_EN adds the travelling range-error bit.
module cordic_hyper_stage
  import cordic_hyper_pkg::*;
#(
  parameter int                   W         = 34,
  parameter int                   TAG_W     = 4,
  parameter int                   SHIFT     = 1,
  parameter logic signed [W-1:0]  ATANH_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 in_mode,
  input  logic signed [W-1:0]  in_x,
  input  logic signed [W-1:0]  in_y,
  input  logic signed [W-1:0]  in_z,
  input  logic [TAG_W-1:0]     in_tag,
`ifdef CORDIC_RANGE_CHK_EN
  input  logic                 in_err,
  output logic                 out_err,
`endif
  output logic                 out_valid,
  output logic                 out_mode,
  output logic signed [W-1:0]  out_x,
  output logic signed [W-1:0]  out_y,
  output logic signed [W-1:0]  out_z,
  output logic [TAG_W-1:0]     out_tag
);

  logic                d_neg;
  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  // d = -1: rotation drives z toward 0, vectoring drives y toward 0
  assign d_neg = (in_mode == MODE_ROT) ? in_z[W-1] : ~in_y[W-1];
  assign x_sh  = in_x >>> SHIFT;
  assign y_sh  = in_y >>> SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      out_tag   <= '0;
`ifdef CORDIC_RANGE_CHK_EN
      out_err   <= 1'b0;
`endif
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_x     <= d_neg ? in_x - y_sh : in_x + y_sh;
      out_y     <= d_neg ? in_y - x_sh : in_y + x_sh;
      out_z     <= d_neg ? in_z + ATANH_VAL : in_z - ATANH_VAL;
      out_tag   <= in_tag;
`ifdef CORDIC_RANGE_CHK_EN
      out_err   <= in_err;
`endif
    end
  end

endmodule

// File: rtl/cordic_hyper_unit.sv
// rtl/cordic_hyper_unit.sv - pipelined hyperbolic CORDIC (rotation/vectoring) with valid/ready
// CORDIC_RANGE_CHK_EN enables input convergence-range checking and out_range_err.
module cordic_hyper_unit
  import cordic_hyper_pkg::*;
#(
  parameter int DW    = 32,
  parameter int FRAC  = 16,
  parameter int ITER  = 16,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DW-1:0]     in_x,
  input  logic [DW-1:0]     in_y,
  input  logic [DW-1:0]     in_z,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_x,
  output logic [DW-1:0]     out_y,
  output logic [DW-1:0]     out_z,
  output logic              out_mode,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_range_err
);

  localparam int W     = DW + 2;
  localparam int NSTEP = nstep(ITER);

  logic                en;
  logic signed [W-1:0] x_ext, y_ext, z_ext, z_chk;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign x_ext    = {{2{in_x[DW-1]}}, in_x};
  assign y_ext    = {{2{in_y[DW-1]}}, in_y};
  assign z_ext    = {{2{in_z[DW-1]}}, in_z};

`ifdef CORDIC_RANGE_CHK_EN
  localparam logic signed [W-1:0] ZMAX = W'(q32_to_frac(ZMAX_Q32, FRAC));
  logic                err_chk;
  logic signed [W-1:0] abs_x, abs_y;

  always_comb begin
    abs_x   = x_ext[W-1] ? -x_ext : x_ext;
    abs_y   = y_ext[W-1] ? -y_ext : y_ext;
    z_chk   = z_ext;
    err_chk = 1'b0;
    if (in_mode == MODE_ROT) begin
      if (z_ext > ZMAX) begin
        z_chk   = ZMAX;
        err_chk = 1'b1;
      end else if (z_ext < -ZMAX) begin
        z_chk   = -ZMAX;
        err_chk = 1'b1;
      end
    end else begin
      err_chk = (x_ext <= 0) || (abs_y >= abs_x);
    end
  end
`else
  assign z_chk = z_ext;
`endif

  logic                r_valid, r_mode;
  logic signed [W-1:0] r_x, r_y, r_z;
  logic [TAG_W-1:0]    r_tag;
`ifdef CORDIC_RANGE_CHK_EN
  logic                r_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_mode  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_tag   <= '0;
`ifdef CORDIC_RANGE_CHK_EN
      r_err   <= 1'b0;
`endif
    end else if (en) begin
      r_valid <= in_valid;
      r_mode  <= in_mode;
      r_x     <= x_ext;
      r_y     <= y_ext;
      r_z     <= z_chk;
      r_tag   <= in_tag;
`ifdef CORDIC_RANGE_CHK_EN
      r_err   <= in_valid & err_chk;
`endif
    end
  end

  logic                s_valid [NSTEP];
  logic                s_mode  [NSTEP];
  logic signed [W-1:0] s_x     [NSTEP];
  logic signed [W-1:0] s_y     [NSTEP];
  logic signed [W-1:0] s_z     [NSTEP];
  logic [TAG_W-1:0]    s_tag   [NSTEP];
`ifdef CORDIC_RANGE_CHK_EN
  logic                s_err   [NSTEP];
`endif

  for (genvar k = 0; k < NSTEP; k++) begin : g_stage
    logic                v_i, m_i;
    logic signed [W-1:0] x_i, y_i, z_i;
    logic [TAG_W-1:0]    t_i;
`ifdef CORDIC_RANGE_CHK_EN
    logic                e_i;
`endif
    if (k == 0) begin : g_first
      assign v_i = r_valid;
      assign m_i = r_mode;
      assign x_i = r_x;
      assign y_i = r_y;
      assign z_i = r_z;
      assign t_i = r_tag;
`ifdef CORDIC_RANGE_CHK_EN
      assign e_i = r_err;
`endif
    end else begin : g_next
      assign v_i = s_valid[k-1];
      assign m_i = s_mode[k-1];
      assign x_i = s_x[k-1];
      assign y_i = s_y[k-1];
      assign z_i = s_z[k-1];
      assign t_i = s_tag[k-1];
`ifdef CORDIC_RANGE_CHK_EN
      assign e_i = s_err[k-1];
`endif
    end

    cordic_hyper_stage #(
      .W         (W),
      .TAG_W     (TAG_W),
      .SHIFT     (stage_index(k)),
      .ATANH_VAL (W'(q32_to_frac(ATANH_Q32[stage_index(k)], FRAC)))
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (v_i),
      .in_mode   (m_i),
      .in_x      (x_i),
      .in_y      (y_i),
      .in_z      (z_i),
      .in_tag    (t_i),
`ifdef CORDIC_RANGE_CHK_EN
      .in_err    (e_i),
      .out_err   (s_err[k]),
`endif
      .out_valid (s_valid[k]),
      .out_mode  (s_mode[k]),
      .out_x     (s_x[k]),
      .out_y     (s_y[k]),
      .out_z     (s_z[k]),
      .out_tag   (s_tag[k])
    );
  end

  function automatic logic [DW-1:0] sat(input logic signed [W-1:0] v);
    if (v[W-1:DW-1] == {3{v[W-1]}})
      return v[DW-1:0];
    return v[W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_mode      <= 1'b0;
      out_x         <= '0;
      out_y         <= '0;
      out_z         <= '0;
      out_tag       <= '0;
`ifdef CORDIC_RANGE_CHK_EN
      out_range_err <= 1'b0;
`endif
    end else if (en) begin
      out_valid     <= s_valid[NSTEP-1];
      out_mode      <= s_mode[NSTEP-1];
      out_x         <= sat(s_x[NSTEP-1]);
      out_y         <= sat(s_y[NSTEP-1]);
      out_z         <= sat(s_z[NSTEP-1]);
      out_tag       <= s_tag[NSTEP-1];
`ifdef CORDIC_RANGE_CHK_EN
      out_range_err <= s_err[NSTEP-1];
`endif
    end
  end

`ifndef CORDIC_RANGE_CHK_EN
  assign out_range_err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_hyper_unit.sv
// tb/tb_cordic_hyper_unit.sv - directed self-checking bench for cordic_hyper_unit
module tb_cordic_hyper_unit;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_mode;
  logic [31:0]       in_x, in_y, in_z;
  logic [3:0]        in_tag;
  logic              out_valid, out_ready, out_mode, out_range_err;
  logic signed [31:0] out_x, out_y, out_z;
  logic [3:0]        out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cordic_hyper_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode       (in_mode),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_z          (in_z),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_z         (out_z),
    .out_mode      (out_mode),
    .out_tag       (out_tag),
    .out_range_err (out_range_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input longint obs, input longint exp, input longint tol);
    n_tests++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Launch one item with an empty pipeline; returns at the negedge where out_valid is first seen.
  // lat counts rising edges from the accepting edge inclusive.
  task automatic run_one(input logic mode, input int x, input int y, input int z,
                         input logic [3:0] tag, output int lat);
    @(negedge clk);
    in_mode   = mode;
    in_x      = x;
    in_y      = y;
    in_z      = z;
    in_tag    = tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check_eq("in_ready_at_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, cnt, got, first, last, seen;
    logic [3:0] exp_tag;
    logic signed [31:0] hold_x;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0; in_z = '0;
    in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_range_err", out_range_err, 0);
    check_eq("reset_out_x", out_x, 0);
    check_eq("reset_out_tag", out_tag, 0);
    check_eq("reset_in_ready", in_ready, 1);
    rst = 1'b0;

    // sinh/cosh of 0.5
    run_one(1'b0, 79135, 0, 32768, 4'h5, lat);
    check_near("rot05_latency", lat, 20, 0);
    check_near("rot05_x", out_x, 73900, 4);
    check_near("rot05_y", out_y, 34151, 4);
    check_near("rot05_z", out_z, 0, 4);
    check_eq("rot05_tag", out_tag, 5);
    check_eq("rot05_mode", out_mode, 0);
    check_eq("rot05_err", out_range_err, 0);
    repeat (3) @(negedge clk);

    run_one(1'b0, 79135, 0, 0, 4'h6, lat);
    check_near("rot0_x", out_x, 65536, 4);
    check_near("rot0_y", out_y, 0, 4);
    repeat (3) @(negedge clk);

    run_one(1'b0, 79135, 0, -65536, 4'h7, lat);
    check_near("rotm1_x", out_x, 101128, 4);
    check_near("rotm1_y", out_y, -77018, 4);
    check_near("rotm1_z", out_z, 0, 4);
    repeat (3) @(negedge clk);

    // atanh(0.5) and K_h*sqrt(3)
    run_one(1'b1, 131072, 65536, 0, 4'h8, lat);
    check_near("vec_latency", lat, 20, 0);
    check_near("vec_z", out_z, 35999, 4);
    check_near("vec_x", out_x, 94006, 4);
    check_near("vec_y", out_y, 0, 4);
    check_eq("vec_mode", out_mode, 1);
    check_eq("vec_err", out_range_err, 0);
    repeat (3) @(negedge clk);

    // backpressure: three back-to-back items, five-cycle stall at first output
    out_ready = 1'b1; in_mode = 1'b0; in_x = 79135; in_y = 0; in_z = 32768;
    for (int k = 1; k <= 3; k++) begin
      in_tag   = k[3:0];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("bp_first_valid", out_valid, 1);
    out_ready = 1'b0;
    hold_x = out_x;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check_eq("bp_in_ready_low", in_ready, 0);
      check_eq("bp_valid_held", out_valid, 1);
      check_eq("bp_tag_held", out_tag, 1);
      check_eq("bp_x_stable", out_x, hold_x);
      check_near("bp_x_value", out_x, 73900, 4);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      check_eq("bp_order_valid", out_valid, 1);
      check_eq("bp_order_tag", out_tag, k);
      @(negedge clk);
    end
    check_eq("bp_drained", out_valid, 0);
    repeat (3) @(negedge clk);

    // 50 random in-range rotations at full rate
    got = 0; first = -1; last = -1; exp_tag = 4'h0;
    for (int c = 0; c < 80; c++) begin
      if (out_valid === 1'b1) begin
        check_eq("rand_tag_order", out_tag, exp_tag);
        exp_tag++;
        got++;
        if (first < 0) first = c;
        last = c;
      end
      if (c < 50) begin
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_x     = 79135;
        in_y     = 0;
        in_z     = int'($urandom_range(131072, 0)) - 65536;
        in_tag   = c[3:0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check_near("rand_count", got, 50, 0);
    check_near("rand_first_cycle", first, 20, 0);
    check_near("rand_back_to_back", last - first + 1, 50, 0);
    repeat (3) @(negedge clk);

    // reset with ten items held in the pipeline
    out_ready = 1'b0; in_mode = 1'b0; in_x = 79135; in_y = 0; in_z = 32768;
    for (int k = 0; k < 10; k++) begin
      in_tag   = k[3:0];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_valid_drop", out_valid, 0);
    check_eq("rst_x_clear", out_x, 0);
    check_eq("rst_tag_clear", out_tag, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    check_near("rst_no_stale", seen, 0, 0);
    run_one(1'b0, 79135, 0, 32768, 4'hA, lat);
    check_near("post_rst_latency", lat, 20, 0);
    check_near("post_rst_x", out_x, 73900, 4);
    check_near("post_rst_y", out_y, 34151, 4);
    check_eq("post_rst_tag", out_tag, 10);
    repeat (3) @(negedge clk);

    // z = 1.5 is beyond the convergence range
    run_one(1'b0, 79135, 0, 98304, 4'h9, lat);
    check_near("range_latency", lat, 20, 0);
`ifdef CORDIC_RANGE_CHK_EN
    check_eq("range_err_set", out_range_err, 1);
    check_near("range_clamp_x", out_x, 110961, 8);
    check_near("range_clamp_y", out_y, 89538, 8);
`else
    check_eq("range_err_off", out_range_err, 0);
`endif
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
